// File: rtl/instruction_pkg.sv
// Shared RV32I(+M) decode definitions: opcodes, immediate kinds, the decoded
// instruction record handed from ID to EXE, and immediate sign extension.
package instruction_pkg;

    localparam int ARCH_LEN     = 32;
    localparam int REG_FILE_LEN = 32;
    localparam int RA_W         = $clog2(REG_FILE_LEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] FUNC7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S} imm_type_e;

    typedef enum logic {ST_RUN, ST_BUBBLE} stage_state_e;

    typedef struct packed {
        logic                valid;
        logic                is_reg_reg;
        logic                is_load;
        logic                is_store;
        logic                is_mul;
        logic                reg_write_enable;
        logic                reg_data_ready;
        logic [RA_W-1:0]     dst_reg;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic [ARCH_LEN-1:0] src_data_1;
        logic [ARCH_LEN-1:0] src_data_2;
        logic [ARCH_LEN-1:0] imm;
        logic [ARCH_LEN-1:0] dst_reg_data;
    } inst_decoded_t;

    // hi = instr[31:25], lo_i = instr[24:20], lo_s = instr[11:7]
    function automatic logic [ARCH_LEN-1:0] sext_imm(input logic [6:0] hi,
                                                     input logic [4:0] lo_i,
                                                     input logic [4:0] lo_s,
                                                     input imm_type_e  kind);
        logic signed [11:0] raw;
        case (kind)
            IMM_I:   raw = {hi, lo_i};
            IMM_S:   raw = {hi, lo_s};
            default: raw = '0;
        endcase
        return ARCH_LEN'(raw);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle around the ID stage: fetch handshake, register-file read port,
// flush and the ID->EXE handshake. The stage is the slave side.
interface decode_stage_if;
    import instruction_pkg::*;

    logic                if_valid_i;
    logic                if_ready_o;
    logic [31:0]         if_instr_i;
    logic [RA_W-1:0]     rf_raddr1_o;
    logic [RA_W-1:0]     rf_raddr2_o;
    logic [ARCH_LEN-1:0] rf_rdata1_i;
    logic [ARCH_LEN-1:0] rf_rdata2_i;
    logic                flush_i;
    logic                id_valid_o;
    logic                id_ready_i;
    inst_decoded_t       id_inst_o;
    logic                illegal_o;

    modport slave (
        input  if_valid_i, if_instr_i, rf_rdata1_i, rf_rdata2_i, flush_i, id_ready_i,
        output if_ready_o, rf_raddr1_o, rf_raddr2_o, id_valid_o, id_inst_o, illegal_o
    );

    modport master (
        output if_valid_i, if_instr_i, rf_rdata1_i, rf_rdata2_i, flush_i, id_ready_i,
        input  if_ready_o, rf_raddr1_o, rf_raddr2_o, id_valid_o, id_inst_o, illegal_o
    );

endinterface

// File: rtl/inst_decoder.sv
// Combinational RV32I word decoder producing inst_decoded_t plus illegal flag.
// Optional feature macro: M_EXT_EN (accepts the MUL/DIV func7 on OP).
module inst_decoder
    import instruction_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [ARCH_LEN-1:0] rs1_data,
    input  logic [ARCH_LEN-1:0] rs2_data,
    output inst_decoded_t       dec,
    output logic                illegal,
    output logic [RA_W-1:0]     rs1_addr,
    output logic [RA_W-1:0]     rs2_addr,
    output logic                uses_rs1,
    output logic                uses_rs2
);

    logic [6:0]      opcode;
    logic [6:0]      func7;
    logic [RA_W-1:0] rd;
    imm_type_e       imm_type;
    logic            wr_cand;

    assign opcode   = instr[6:0];
    assign func7    = instr[31:25];
    assign rd       = instr[7 +: RA_W];
    assign rs1_addr = instr[15 +: RA_W];
    assign rs2_addr = instr[20 +: RA_W];
    assign uses_rs1 = !illegal;

    always_comb begin
        dec            = '0;
        illegal        = 1'b0;
        imm_type       = IMM_NONE;
        wr_cand        = 1'b0;
        uses_rs2       = 1'b0;
        dec.valid      = 1'b1;
        dec.dst_reg    = rd;
        dec.func3      = instr[14:12];
        dec.func7      = func7;
        dec.src_data_1 = rs1_data;

        case (opcode)
            OPC_OP: begin
                if (func7 == FUNC7_BASE || func7 == FUNC7_ALT) begin
                    dec.is_reg_reg = 1'b1;
                    dec.src_data_2 = rs2_data;
                    wr_cand        = 1'b1;
                    uses_rs2       = 1'b1;
                end
`ifdef M_EXT_EN
                else if (func7 == FUNC7_MULDIV) begin
                    dec.is_reg_reg = 1'b1;
                    dec.is_mul     = 1'b1;
                    dec.src_data_2 = rs2_data;
                    wr_cand        = 1'b1;
                    uses_rs2       = 1'b1;
                end
`endif
                else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                imm_type = IMM_I;
                wr_cand  = 1'b1;
            end
            OPC_LOAD: begin
                dec.is_load = 1'b1;
                imm_type    = IMM_I;
                wr_cand     = 1'b1;
            end
            OPC_STORE: begin
                dec.is_store   = 1'b1;
                imm_type       = IMM_S;
                dec.src_data_2 = rs2_data;
                uses_rs2       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        dec.imm = sext_imm(instr[31:25], instr[24:20], instr[11:7], imm_type);
        // Stores carry rs2 data on src2; the immediate is only for address generation.
        if (imm_type != IMM_NONE && !dec.is_store) begin
            dec.src_data_2 = dec.imm;
        end
        dec.reg_write_enable = wr_cand && (rd != '0);
        dec.reg_data_ready   = !dec.is_load && !dec.is_mul;
    end

endmodule

// File: rtl/decode_stage.sv
// ID pipeline stage: fetch handshake, load-use hazard bubble, flush and the
// registered ID->EXE record. Optional feature macro: M_EXT_EN (in inst_decoder).
module decode_stage
    import instruction_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);

    inst_decoded_t   dec;
    logic            dec_illegal;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic            uses_rs1;
    logic            uses_rs2;

    inst_decoded_t   inst_p0;
    logic            illegal_p0;
    logic            vld_p0;
    stage_state_e    state;

    logic            hazard;
    logic            if_ready;
    logic            accept;

    inst_decoder u_dec (
        .instr    (bus.if_instr_i),
        .rs1_data (bus.rf_rdata1_i),
        .rs2_data (bus.rf_rdata2_i),
        .dec      (dec),
        .illegal  (dec_illegal),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign vld_p0 = inst_p0.valid;

    // A load still in ID whose result the offered word needs: hold the word back.
    assign hazard = bus.if_valid_i && vld_p0 && inst_p0.is_load &&
                    inst_p0.reg_write_enable && (inst_p0.dst_reg != '0) &&
                    ((uses_rs1 && inst_p0.dst_reg == rs1_addr) ||
                     (uses_rs2 && inst_p0.dst_reg == rs2_addr));

    assign if_ready = (!vld_p0 || bus.id_ready_i) && !hazard &&
                      (state == ST_RUN) && !bus.flush_i;
    assign accept   = bus.if_valid_i && if_ready;

    assign bus.if_ready_o  = if_ready;
    assign bus.rf_raddr1_o = rs1_addr;
    assign bus.rf_raddr2_o = rs2_addr;
    assign bus.id_valid_o  = vld_p0;
    assign bus.id_inst_o   = inst_p0;
    assign bus.illegal_o   = illegal_p0;

    // ---- ID -> EXE register and bubble FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_p0    <= '0;
            illegal_p0 <= 1'b0;
            state      <= ST_RUN;
        end else if (bus.flush_i) begin
            inst_p0.valid <= 1'b0;
            illegal_p0    <= 1'b0;
            state         <= ST_RUN;
        end else begin
            if (accept) begin
                inst_p0    <= dec;
                illegal_p0 <= dec_illegal;
            end else if (bus.id_ready_i) begin
                inst_p0.valid <= 1'b0;
                illegal_p0    <= 1'b0;
            end

            case (state)
                ST_RUN:    if (hazard && bus.id_ready_i) state <= ST_BUBBLE;
                ST_BUBBLE: state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus hand-written
// hazard, backpressure, flush and reset sequences.
module tb_decode_stage;
    import instruction_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_ADDI = 32'h00128313;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_DEP  = 32'h002283B3;
    localparam int NV = 11;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        rr, ld, st, mul, we, rdr, ill;
        logic [4:0]  dst;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [NV];
    int n_total = 0;
    int n_pass  = 0;
    logic [140:0] act_v;
    logic [140:0] exp_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [140:0] act, input logic [140:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                         input logic [31:0] d2, input logic rdy);
        bus.if_valid_i  = v;
        bus.if_instr_i  = ins;
        bus.rf_rdata1_i = d1;
        bus.rf_rdata2_i = d2;
        bus.id_ready_i  = rdy;
    endtask

    initial begin
        //          instr          rd1     rd2     rr   ld   st   mul  we   rdr  ill  dst    s1      s2             imm
        vecs[0]  = '{32'h002081B3, 32'd5,   32'd7,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd3,  32'd5,   32'd7,         32'd0};
        vecs[1]  = '{32'h00128313, 32'd10,  32'd99, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd6,  32'd10,  32'd1,         32'd1};
        vecs[2]  = '{32'h0080A283, 32'd100, 32'd99, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd5,  32'd100, 32'd8,         32'd8};
        vecs[3]  = '{32'h0020A623, 32'd64,  32'd77, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,5'd12, 32'd64,  32'd77,        32'd12};
        vecs[4]  = '{32'hFFF00393, 32'd0,   32'd3,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd7,  32'd0,   32'hFFFFFFFF,  32'hFFFFFFFF};
        vecs[5]  = '{32'hFE312E23, 32'd200, 32'd33, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,5'd28, 32'd200, 32'd33,        32'hFFFFFFFC};
        vecs[6]  = '{32'h00508013, 32'd9,   32'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0,  32'd9,   32'd5,         32'd5};
        vecs[7]  = '{32'h123450B7, 32'd4,   32'd6,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd1,  32'd4,   32'd0,         32'd0};
        vecs[8]  = '{32'h402081B3, 32'd20,  32'd8,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,5'd3,  32'd20,  32'd8,         32'd0};
        vecs[9]  = '{32'hFE2081B3, 32'd1,   32'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd3,  32'd1,   32'd0,         32'd0};
`ifdef M_EXT_EN
        vecs[10] = '{32'h02208233, 32'd6,   32'd7,  1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd4,  32'd6,   32'd7,         32'd0};
`else
        vecs[10] = '{32'h02208233, 32'd6,   32'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,5'd4,  32'd6,   32'd0,         32'd0};
`endif

        offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        bus.flush_i = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst_zero", 32'(bus.id_inst_o != '0), 32'd0);
        chk("reset_ctrl", 32'({bus.id_valid_o, bus.illegal_o, bus.if_ready_o}), 32'b001);
        @(negedge clk) rst_n = 1'b1;

        // Decode table: one word per slot, followed by an idle slot that drains it.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            offer(1'b1, vecs[i].instr, vecs[i].rd1, vecs[i].rd2, 1'b1);
            @(posedge clk); #1;
            act_v = {bus.id_valid_o, bus.id_inst_o.is_reg_reg, bus.id_inst_o.is_load,
                     bus.id_inst_o.is_store, bus.id_inst_o.is_mul, bus.id_inst_o.reg_write_enable,
                     bus.id_inst_o.reg_data_ready, bus.illegal_o, bus.id_inst_o.dst_reg,
                     bus.id_inst_o.src_data_1, bus.id_inst_o.src_data_2, bus.id_inst_o.imm,
                     bus.id_inst_o.dst_reg_data};
            exp_v = {1'b1, vecs[i].rr, vecs[i].ld, vecs[i].st, vecs[i].mul, vecs[i].we,
                     vecs[i].rdr, vecs[i].ill, vecs[i].dst, vecs[i].s1, vecs[i].s2,
                     vecs[i].imm, 32'd0};
            chkw($sformatf("vec%0d_%08h", i, vecs[i].instr), act_v, exp_v);
            @(negedge clk);
            offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
            @(posedge clk); #1;
        end
        chk("drain_valid", 32'(bus.id_valid_o), 32'd0);

        // Backpressure: ADD held three cycles while inputs change underneath.
        @(negedge clk) offer(1'b1, I_ADD, 32'd5, 32'd7, 1'b1);
        @(posedge clk); #1;
        chk("bp_load", 32'({bus.id_valid_o, bus.id_inst_o.dst_reg}), 32'({1'b1, 5'd3}));
        @(negedge clk) offer(1'b1, I_SUB, 32'd11, 32'd99, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_src2_c%0d", c), bus.id_inst_o.src_data_2, 32'd7);
            chk($sformatf("bp_hold_ctl_c%0d", c),
                32'({bus.id_valid_o, bus.id_inst_o.func7, bus.if_ready_o}), 32'({1'b1, 7'd0, 1'b0}));
        end
        @(negedge clk) bus.id_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_sub", 32'({bus.id_valid_o, bus.id_inst_o.func7, bus.id_inst_o.src_data_2[7:0]}),
            32'({1'b1, 7'h20, 8'd99}));

        // Illegal word held, then flushed with a word on offer.
        @(negedge clk) offer(1'b1, I_LUI, 32'd4, 32'd6, 1'b1);
        @(posedge clk); #1;
        chk("illegal_load", 32'({bus.id_valid_o, bus.illegal_o}), 32'b11);
        @(negedge clk) offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("illegal_held", 32'({bus.id_valid_o, bus.illegal_o}), 32'b11);
        @(negedge clk);
        offer(1'b1, I_ADDI, 32'd10, 32'd0, 1'b0);
        bus.flush_i = 1'b1;
        #1 chk("flush_if_ready", 32'(bus.if_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("flush_clear", 32'({bus.id_valid_o, bus.illegal_o}), 32'b00);
        @(negedge clk);
        bus.flush_i = 1'b0;
        offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("flush_dropped", 32'(bus.id_valid_o), 32'd0);

        // Load-use: LW x5 then ADDI x6,x5,1.
        @(negedge clk) offer(1'b1, I_LW, 32'd100, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("lu_lw", 32'({bus.id_valid_o, bus.id_inst_o.is_load, bus.id_inst_o.reg_data_ready}), 32'b110);
        @(negedge clk) offer(1'b1, I_ADDI, 32'd10, 32'd0, 1'b0);
        #1 chk("lu_raddr1", 32'(bus.rf_raddr1_o), 32'd5);
        chk("lu_stall_ready", 32'(bus.if_ready_o), 32'd0);
        @(negedge clk) bus.id_ready_i = 1'b1;
        #1 chk("lu_handoff_ready", 32'({bus.if_ready_o, bus.id_inst_o.is_load}), 32'b01);
        @(posedge clk); #1;
        chk("lu_bubble", 32'({bus.id_valid_o, bus.if_ready_o}), 32'b00);
        @(posedge clk); #1;
        chk("lu_run_again", 32'({bus.id_valid_o, bus.if_ready_o}), 32'b01);
        @(posedge clk); #1;
        chk("lu_addi", 32'({bus.id_valid_o, bus.id_inst_o.dst_reg, bus.id_inst_o.imm[7:0]}),
            32'({1'b1, 5'd6, 8'd1}));
        @(negedge clk) offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        @(posedge clk); #1;

        // Reset while a valid entry is stalled.
        @(negedge clk) offer(1'b1, I_ADD, 32'd5, 32'd7, 1'b1);
        @(posedge clk); #1;
        @(negedge clk) offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst_stall_async", 32'({bus.id_valid_o, bus.id_inst_o != '0}), 32'b00);
        @(negedge clk) rst_n = 1'b1;

        // Reset while in BUBBLE.
        @(negedge clk) offer(1'b1, I_LW, 32'd100, 32'd0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk) offer(1'b1, I_DEP, 32'd1, 32'd2, 1'b1);
        @(posedge clk); #1;
        chk("bub_entered", 32'({bus.id_valid_o, bus.if_ready_o}), 32'b00);
        #2 rst_n = 1'b0;
        #1 chk("rst_bubble_async", 32'({bus.id_valid_o, bus.illegal_o, bus.id_inst_o != '0}), 32'b000);
        #1 rst_n = 1'b1;
        #1 chk("rst_bubble_run", 32'(bus.if_ready_o), 32'd1);
        @(posedge clk); #1;
        chk("post_rst_accept", 32'({bus.id_valid_o, bus.id_inst_o.dst_reg}), 32'({1'b1, 5'd7}));
        @(negedge clk) offer(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
